// File: rtl/control_unit.sv
`default_nettype none
// ============================================================================
// Module   : control_unit
// Brief    : Multicycle MIPS main control FSM; Moore decode of all datapath
//            selects and strobes (BRANCH PCWrite also follows ALU zero).
// Revision : 1.0 - initial release
// ============================================================================
module control_unit #(
    parameter int STATE_W = 5
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    input  logic               overflow,
    input  logic               zero,
    output logic               PCWrite,
    output logic [1:0]         IorD,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               MDRWrite,
    output logic               RegWrite,
    output logic [1:0]         RegDst,
    output logic [2:0]         MemToReg,
    output logic               LoadAB,
    output logic               LoadALUOut,
    output logic               LoadEPC,
    output logic [1:0]         ALUSrcA,
    output logic [2:0]         ALUSrcB,
    output logic [2:0]         ALUControl,
    output logic [1:0]         PCSrc,
    output logic [STATE_W-1:0] state
);

    localparam logic [STATE_W-1:0] c_st_reset       = STATE_W'(0);
    localparam logic [STATE_W-1:0] c_st_fetch       = STATE_W'(1);
    localparam logic [STATE_W-1:0] c_st_fetch_wait  = STATE_W'(2);
    localparam logic [STATE_W-1:0] c_st_ir_load     = STATE_W'(3);
    localparam logic [STATE_W-1:0] c_st_decode      = STATE_W'(4);
    localparam logic [STATE_W-1:0] c_st_exec_r      = STATE_W'(5);
    localparam logic [STATE_W-1:0] c_st_alu_wb      = STATE_W'(6);
    localparam logic [STATE_W-1:0] c_st_exec_i      = STATE_W'(7);
    localparam logic [STATE_W-1:0] c_st_mem_addr    = STATE_W'(8);
    localparam logic [STATE_W-1:0] c_st_mem_rd      = STATE_W'(9);
    localparam logic [STATE_W-1:0] c_st_mem_rd_wait = STATE_W'(10);
    localparam logic [STATE_W-1:0] c_st_load_wb     = STATE_W'(11);
    localparam logic [STATE_W-1:0] c_st_mem_wr      = STATE_W'(12);
    localparam logic [STATE_W-1:0] c_st_branch      = STATE_W'(13);
    localparam logic [STATE_W-1:0] c_st_jump        = STATE_W'(14);
    localparam logic [STATE_W-1:0] c_st_jal         = STATE_W'(15);
    localparam logic [STATE_W-1:0] c_st_jal_wb      = STATE_W'(16);
    localparam logic [STATE_W-1:0] c_st_lui         = STATE_W'(17);
    localparam logic [STATE_W-1:0] c_st_jr          = STATE_W'(18);
    localparam logic [STATE_W-1:0] c_st_exc_epc     = STATE_W'(19);
    localparam logic [STATE_W-1:0] c_st_exc_jmp     = STATE_W'(20);

    localparam logic [5:0] c_op_rtype = 6'h00;
    localparam logic [5:0] c_op_addi  = 6'h08;
    localparam logic [5:0] c_op_lw    = 6'h23;
    localparam logic [5:0] c_op_sw    = 6'h2B;
    localparam logic [5:0] c_op_beq   = 6'h04;
    localparam logic [5:0] c_op_bne   = 6'h05;
    localparam logic [5:0] c_op_j     = 6'h02;
    localparam logic [5:0] c_op_jal   = 6'h03;
    localparam logic [5:0] c_op_lui   = 6'h0F;

    localparam logic [5:0] c_fn_add = 6'h20;
    localparam logic [5:0] c_fn_sub = 6'h22;
    localparam logic [5:0] c_fn_and = 6'h24;
    localparam logic [5:0] c_fn_jr  = 6'h08;

    localparam logic [2:0] c_alu_pass = 3'b000;
    localparam logic [2:0] c_alu_add  = 3'b001;
    localparam logic [2:0] c_alu_sub  = 3'b010;
    localparam logic [2:0] c_alu_and  = 3'b011;

    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] w_next_state;
    logic               w_fn_add_sub;

    // Only add/sub can trap on overflow; and never does.
    assign w_fn_add_sub = (funct == c_fn_add) || (funct == c_fn_sub);

    always_comb begin
        w_next_state = c_st_reset;
        case (r_state)
            c_st_reset:       w_next_state = c_st_fetch;
            c_st_fetch:       w_next_state = c_st_fetch_wait;
            c_st_fetch_wait:  w_next_state = c_st_ir_load;
            c_st_ir_load:     w_next_state = c_st_decode;
            c_st_decode: begin
                case (opcode)
                    c_op_rtype: begin
                        if (w_fn_add_sub || (funct == c_fn_and))
                            w_next_state = c_st_exec_r;
                        else if (funct == c_fn_jr)
                            w_next_state = c_st_jr;
                        else
                            w_next_state = c_st_exc_epc;
                    end
                    c_op_addi:          w_next_state = c_st_exec_i;
                    c_op_lw, c_op_sw:   w_next_state = c_st_mem_addr;
                    c_op_beq, c_op_bne: w_next_state = c_st_branch;
                    c_op_j:             w_next_state = c_st_jump;
                    c_op_jal:           w_next_state = c_st_jal;
                    c_op_lui:           w_next_state = c_st_lui;
                    default:            w_next_state = c_st_exc_epc;
                endcase
            end
            c_st_exec_r:      w_next_state = (w_fn_add_sub && overflow) ? c_st_exc_epc : c_st_alu_wb;
            c_st_exec_i:      w_next_state = overflow ? c_st_exc_epc : c_st_alu_wb;
            c_st_mem_addr:    w_next_state = (opcode == c_op_sw) ? c_st_mem_wr : c_st_mem_rd;
            c_st_mem_rd:      w_next_state = c_st_mem_rd_wait;
            c_st_mem_rd_wait: w_next_state = c_st_load_wb;
            c_st_jal:         w_next_state = c_st_jal_wb;
            c_st_exc_epc:     w_next_state = c_st_exc_jmp;
            c_st_alu_wb, c_st_load_wb, c_st_mem_wr, c_st_branch, c_st_jump,
            c_st_jal_wb, c_st_lui, c_st_jr, c_st_exc_jmp:
                              w_next_state = c_st_fetch;
            default:          w_next_state = c_st_reset;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset)
            r_state <= c_st_reset;
        else
            r_state <= w_next_state;
    end

    assign state = r_state;

    always_comb begin
        PCWrite    = 1'b0;
        IorD       = 2'b00;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        MDRWrite   = 1'b0;
        RegWrite   = 1'b0;
        RegDst     = 2'b00;
        MemToReg   = 3'b000;
        LoadAB     = 1'b0;
        LoadALUOut = 1'b0;
        LoadEPC    = 1'b0;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 3'b000;
        ALUControl = c_alu_pass;
        PCSrc      = 2'b00;
        case (r_state)
            c_st_reset: begin
                // Stack pointer $29 is initialised to 227 on every reset.
                RegWrite = 1'b1;
                RegDst   = 2'b10;
                MemToReg = 3'b110;
            end
            c_st_fetch, c_st_fetch_wait: begin
                ALUSrcB    = 3'b001;
                ALUControl = c_alu_add;
            end
            c_st_ir_load: begin
                IRWrite = 1'b1;
                PCWrite = 1'b1;
            end
            c_st_decode: begin
                LoadAB     = 1'b1;
                ALUSrcB    = 3'b011;
                ALUControl = c_alu_add;
                LoadALUOut = 1'b1;
            end
            c_st_exec_r: begin
                ALUSrcA    = 2'b01;
                LoadALUOut = 1'b1;
                if (funct == c_fn_sub)
                    ALUControl = c_alu_sub;
                else if (funct == c_fn_and)
                    ALUControl = c_alu_and;
                else
                    ALUControl = c_alu_add;
            end
            c_st_alu_wb: begin
                RegWrite = 1'b1;
                RegDst   = (opcode == c_op_rtype) ? 2'b01 : 2'b00;
            end
            c_st_exec_i, c_st_mem_addr: begin
                ALUSrcA    = 2'b01;
                ALUSrcB    = 3'b010;
                ALUControl = c_alu_add;
                LoadALUOut = 1'b1;
            end
            c_st_mem_rd: begin
                IorD = 2'b10;
            end
            c_st_mem_rd_wait: begin
                IorD     = 2'b10;
                MDRWrite = 1'b1;
            end
            c_st_load_wb: begin
                RegWrite = 1'b1;
                MemToReg = 3'b001;
            end
            c_st_mem_wr: begin
                IorD     = 2'b10;
                MemWrite = 1'b1;
            end
            c_st_branch: begin
                ALUSrcA    = 2'b01;
                ALUControl = c_alu_sub;
                PCSrc      = 2'b01;
                PCWrite    = (opcode == c_op_beq) ? zero : ~zero;
            end
            c_st_jump: begin
                PCWrite = 1'b1;
                PCSrc   = 2'b10;
            end
            c_st_jal: begin
                LoadALUOut = 1'b1;
            end
            c_st_jal_wb: begin
                RegWrite = 1'b1;
                RegDst   = 2'b11;
                PCWrite  = 1'b1;
                PCSrc    = 2'b10;
            end
            c_st_lui: begin
                RegWrite = 1'b1;
                MemToReg = 3'b101;
            end
            c_st_jr: begin
                ALUSrcA = 2'b01;
                PCWrite = 1'b1;
            end
            c_st_exc_epc: begin
                // PC already advanced past the faulting word; EPC gets PC-4.
                ALUSrcB    = 3'b001;
                ALUControl = c_alu_sub;
                LoadEPC    = 1'b1;
            end
            c_st_exc_jmp: begin
                PCWrite = 1'b1;
                PCSrc   = 2'b11;
            end
            default: begin
                PCWrite = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_control_unit
// Brief    : Scoreboard bench for control_unit with an instruction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_control_unit;

    typedef struct packed {
        logic       pc_write;
        logic [1:0] iord;
        logic       mem_write;
        logic       ir_write;
        logic       mdr_write;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [2:0] mem_to_reg;
        logic       load_ab;
        logic       load_aluout;
        logic       load_epc;
        logic [1:0] alu_src_a;
        logic [2:0] alu_src_b;
        logic [2:0] alu_ctl;
        logic [1:0] pc_src;
    } ctrl_t;

    typedef struct packed {
        logic [4:0] st;
        ctrl_t      c;
    } obs_t;

    logic       clk;
    logic       rst;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       overflow;
    logic       zero;
    logic       PCWrite, MemWrite, IRWrite, MDRWrite, RegWrite;
    logic       LoadAB, LoadALUOut, LoadEPC;
    logic [1:0] IorD, RegDst, ALUSrcA, PCSrc;
    logic [2:0] MemToReg, ALUSrcB, ALUControl;
    logic [4:0] state;

    obs_t sb[$];
    int   n_total;
    int   n_pass;

    control_unit #(.STATE_W(5)) dut (
        .clock(clk), .reset(rst), .opcode(opcode), .funct(funct),
        .overflow(overflow), .zero(zero), .PCWrite(PCWrite), .IorD(IorD),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .MDRWrite(MDRWrite),
        .RegWrite(RegWrite), .RegDst(RegDst), .MemToReg(MemToReg),
        .LoadAB(LoadAB), .LoadALUOut(LoadALUOut), .LoadEPC(LoadEPC),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl),
        .PCSrc(PCSrc), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Control word the specification lists for a given state of an instruction.
    function automatic obs_t expect_for(int st, logic [5:0] opc, logic [5:0] fn, logic z);
        obs_t e;
        e = '0;
        e.st = 5'(st);
        case (st)
            0:  begin e.c.reg_write = 1; e.c.reg_dst = 2'b10; e.c.mem_to_reg = 3'b110; end
            1, 2: begin e.c.alu_src_b = 3'b001; e.c.alu_ctl = 3'b001; end
            3:  begin e.c.ir_write = 1; e.c.pc_write = 1; end
            4:  begin e.c.load_ab = 1; e.c.alu_src_b = 3'b011; e.c.alu_ctl = 3'b001; e.c.load_aluout = 1; end
            5:  begin
                    e.c.alu_src_a = 2'b01; e.c.load_aluout = 1;
                    e.c.alu_ctl = (fn == 6'h22) ? 3'b010 : (fn == 6'h24) ? 3'b011 : 3'b001;
                end
            6:  begin e.c.reg_write = 1; e.c.reg_dst = (opc == 6'h00) ? 2'b01 : 2'b00; end
            7, 8: begin e.c.alu_src_a = 2'b01; e.c.alu_src_b = 3'b010; e.c.alu_ctl = 3'b001; e.c.load_aluout = 1; end
            9:  e.c.iord = 2'b10;
            10: begin e.c.iord = 2'b10; e.c.mdr_write = 1; end
            11: begin e.c.reg_write = 1; e.c.mem_to_reg = 3'b001; end
            12: begin e.c.iord = 2'b10; e.c.mem_write = 1; end
            13: begin
                    e.c.alu_src_a = 2'b01; e.c.alu_ctl = 3'b010; e.c.pc_src = 2'b01;
                    e.c.pc_write = (opc == 6'h04) ? z : ~z;
                end
            14: begin e.c.pc_write = 1; e.c.pc_src = 2'b10; end
            15: e.c.load_aluout = 1;
            16: begin e.c.reg_write = 1; e.c.reg_dst = 2'b11; e.c.pc_write = 1; e.c.pc_src = 2'b10; end
            17: begin e.c.reg_write = 1; e.c.mem_to_reg = 3'b101; end
            18: begin e.c.alu_src_a = 2'b01; e.c.pc_write = 1; end
            19: begin e.c.alu_src_b = 3'b001; e.c.alu_ctl = 3'b010; e.c.load_epc = 1; end
            20: begin e.c.pc_write = 1; e.c.pc_src = 2'b11; end
            default: e = '0;
        endcase
        return e;
    endfunction

    function automatic bit legal_op(logic [5:0] opc);
        return opc inside {6'h00, 6'h08, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h03, 6'h0F};
    endfunction

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    // Issue one instruction; cut>0 asserts reset during the cut-th cycle.
    task automatic run_instr(input logic [5:0] opc, input logic [5:0] fn,
                             input logic ovf, input logic z, input int cut);
        int path[$];
        int n;
        path = '{1, 2, 3, 4};
        case (opc)
            6'h00: begin
                if (fn inside {6'h20, 6'h22, 6'h24}) begin
                    path.push_back(5);
                    if (ovf && fn != 6'h24) begin path.push_back(19); path.push_back(20); end
                    else path.push_back(6);
                end else if (fn == 6'h08) begin
                    path.push_back(18);
                end else begin
                    path.push_back(19); path.push_back(20);
                end
            end
            6'h08: begin
                path.push_back(7);
                if (ovf) begin path.push_back(19); path.push_back(20); end
                else path.push_back(6);
            end
            6'h23: begin path.push_back(8); path.push_back(9); path.push_back(10); path.push_back(11); end
            6'h2B: begin path.push_back(8); path.push_back(12); end
            6'h04, 6'h05: path.push_back(13);
            6'h02: path.push_back(14);
            6'h03: begin path.push_back(15); path.push_back(16); end
            6'h0F: path.push_back(17);
            default: begin path.push_back(19); path.push_back(20); end
        endcase
        n = (cut > 0 && cut < path.size()) ? cut : path.size();
        opcode = opc; funct = fn; overflow = ovf; zero = z;
        for (int i = 0; i < n; i++) sb.push_back(expect_for(path[i], opc, fn, z));
        if (cut > 0) begin
            repeat (n - 1) advance();
            rst = 1'b1;
            advance();
            sb.push_back(expect_for(0, opc, fn, z));
            rst = 1'b0;
            advance();
        end else begin
            repeat (n) advance();
        end
    endtask

    // Monitor: one observation per cycle, compared against the queue head.
    initial begin
        obs_t act;
        obs_t exp;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                exp = sb.pop_front();
                act.st = state;
                act.c.pc_write = PCWrite;     act.c.iord = IorD;
                act.c.mem_write = MemWrite;   act.c.ir_write = IRWrite;
                act.c.mdr_write = MDRWrite;   act.c.reg_write = RegWrite;
                act.c.reg_dst = RegDst;       act.c.mem_to_reg = MemToReg;
                act.c.load_ab = LoadAB;       act.c.load_aluout = LoadALUOut;
                act.c.load_epc = LoadEPC;     act.c.alu_src_a = ALUSrcA;
                act.c.alu_src_b = ALUSrcB;    act.c.alu_ctl = ALUControl;
                act.c.pc_src = PCSrc;
                n_total++;
                if (act !== exp)
                    $display("FAIL ctrl_word t=%0t op=%h fn=%h: actual state=%0d word=%h, required state=%0d word=%h",
                             $time, opcode, funct, act.st, act.c, exp.st, exp.c);
                else
                    n_pass++;
            end
        end
    end

    initial begin
        logic [5:0] opc;
        logic [5:0] fn;
        int         k;
        int         cut;
        n_total = 0; n_pass = 0;
        rst = 1'b1; opcode = 6'h00; funct = 6'h00; overflow = 1'b0; zero = 1'b0;
        advance();
        sb.push_back(expect_for(0, 6'h00, 6'h00, 1'b0));
        rst = 1'b0;
        advance();

        run_instr(6'h00, 6'h20, 1'b0, 1'b0, 0);   // add
        run_instr(6'h23, 6'h00, 1'b0, 1'b0, 0);   // lw
        run_instr(6'h04, 6'h00, 1'b0, 1'b1, 0);   // beq taken
        run_instr(6'h04, 6'h00, 1'b0, 1'b0, 0);   // beq not taken
        run_instr(6'h05, 6'h00, 1'b0, 1'b1, 0);   // bne not taken
        run_instr(6'h05, 6'h00, 1'b0, 1'b0, 0);   // bne taken
        run_instr(6'h08, 6'h00, 1'b1, 1'b0, 0);   // addi overflow trap
        run_instr(6'h00, 6'h22, 1'b1, 1'b0, 0);   // sub overflow trap
        run_instr(6'h00, 6'h24, 1'b1, 1'b0, 0);   // and ignores overflow
        run_instr(6'h3F, 6'h00, 1'b0, 1'b0, 0);   // illegal opcode
        run_instr(6'h2B, 6'h00, 1'b0, 1'b0, 6);   // reset during MEM_WR
        run_instr(6'h23, 6'h00, 1'b1, 1'b0, 0);   // lw ignores overflow

        for (int i = 0; i < 80; i++) begin
            k  = $urandom_range(0, 13);
            fn = 6'($urandom_range(0, 63));
            case (k)
                0: begin opc = 6'h00; fn = 6'h20; end
                1: begin opc = 6'h00; fn = 6'h22; end
                2: begin opc = 6'h00; fn = 6'h24; end
                3: begin opc = 6'h00; fn = 6'h08; end
                4: begin
                       opc = 6'h00;
                       while (fn inside {6'h20, 6'h22, 6'h24, 6'h08}) fn = 6'($urandom_range(0, 63));
                   end
                5:  opc = 6'h08;
                6:  opc = 6'h23;
                7:  opc = 6'h2B;
                8:  opc = 6'h04;
                9:  opc = 6'h05;
                10: opc = 6'h02;
                11: opc = 6'h03;
                12: opc = 6'h0F;
                default: begin
                    opc = 6'($urandom_range(0, 63));
                    while (legal_op(opc)) opc = 6'($urandom_range(0, 63));
                end
            endcase
            cut = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 6)) : 0;
            run_instr(opc, fn, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), cut);
        end

        @(negedge clk);
        #1;
        n_total++;
        if (sb.size() != 0)
            $display("FAIL scoreboard_drain: actual %0d entries left, required 0", sb.size());
        else
            n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
